mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer side of the EX/MEM pipeline register.
- Takes the registered ALU result, next-select address and control, and performs loads/stores over a req/gnt/rvalid data-memory handshake.
- Aligns and sign-extends load data, then registers the write-back value into the MEM/WB boundary.
- Stalls upstream pipe registers while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM register holds a valid instruction
- alu_res  in  32  ALU result / effective address
- next_sel_addr  in  32  PC+4 link value for JAL/JALR
- store_data  in  32  rs2 value for stores
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- funct3  in  3  [1:0] size: 00=B, 01=H, 10=W, 11=illegal; [2]=unsigned load
- wb_sel  in  2  00=alu_res, 01=load data, 10=next_sel_addr, 11=alu_res
- rd  in  5  destination register
- reg_write  in  1  destination write enable
- stall_out  out  1  freeze EX/MEM and earlier registers (combinational)
- dmem_req  out  1  memory request, held until granted
- dmem_we  out  1  1=store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wmask  out  4  byte-lane write mask
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  write-back stage holds a valid instruction
- wb_rd  out  5  write-back destination
- wb_reg_write  out  1  write-back enable
- wb_data  out  32  write-back value
- misalign_err  out  1  one-cycle pulse with the faulting instruction's wb_valid

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask = 0.
  - wb_valid, wb_rd, wb_reg_write, wb_data, misalign_err = 0.
  - stall_out forced 0 while rst=1.
  - Reset mid-access abandons the access; any later rvalid is ignored.
- memop = ex_valid & (mem_read|mem_write).
- aligned:
  - size B: always aligned.
  - size H: addr[0]=0.
  - size W: addr[1:0]=0.
  - size 11: never aligned.
- FSM states IDLE, REQ, RESP:
  - IDLE, non-memop: every edge registers wb_* from inputs (1-cycle latency). wb_valid=ex_valid, wb_data per wb_sel. No stall.
  - IDLE, memop & !aligned: no request issued. Next edge sets wb_valid=1, wb_reg_write=0, misalign_err=1 for one cycle. No stall.
  - IDLE, memop & aligned:
    - stall_out=1.
    - Next edge: capture request into internal regs, set dmem_req=1, dmem_we=mem_write, address/data/mask, go to REQ.
    - wb_valid=0 (bubble).
  - REQ: dmem_req held stable until dmem_gnt=1.
    - Store + gnt: completion cycle.
    - Load + gnt without rvalid: go to RESP. dmem_req drops on that edge.
    - Load + gnt with rvalid in the same cycle: completion cycle.
  - RESP: wait for dmem_rvalid. rvalid arriving marks the completion cycle.
  - Completion cycle:
    - stall_out=0.
    - At that edge: wb_* load with captured rd/reg_write, wb_valid=1, dmem_req=0, state=IDLE.
    - Upstream advances on the same edge.
  - stall_out=1 in REQ and RESP except in the completion cycle. wb_valid=0 while stalled.
- Store lanes, off=addr[1:0]:
  - B: wdata={4{sd[7:0]}}, wmask=0001<<off.
  - H: wdata={2{sd[15:0]}}, wmask=0011<<off.
  - W: wdata=sd, wmask=1111.
- Loads extract byte/halfword at off from dmem_rdata, sign-extend unless funct3[2]=1.
  - W ignores funct3[2].
  - wb_data=extracted value when wb_sel=01.
- Stores complete with wb_reg_write forced 0.
- dmem_rvalid/gnt seen in IDLE are ignored.

Test Plan:
- ALU op: ex_valid=1, alu_res=0x1234, wb_sel=00, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall_out never 1.
- LB signed: addr=0x103, rdata=0x80FF_0000, gnt cycle 2, rvalid cycle 4 -> dmem_addr=0x100, stall_out high until rvalid cycle, wb_data=0xFFFF_FF80, bubble wb_valid=0 before.
- SH: addr=0x202, store_data=0xAAAA_BEEF, gnt delayed 3 cycles -> dmem_req held 3+1 cycles, wmask=1100, wdata=0xBEEF_BEEF, wb_reg_write=0.
- LHU with gnt and rvalid same cycle: addr=0x4, rdata=0x0000_9ABC -> completes that cycle, wb_data=0x0000_9ABC.
- Misaligned LW addr=0x6 -> dmem_req stays 0, misalign_err=1 one cycle, wb_reg_write=0, no stall.
- Reset asserted during RESP, then stray rvalid -> all outputs 0, state IDLE, rvalid ignored, next ALU op writes back normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory req/gnt/rvalid handshake for
// loads and stores, aligns load data and registers the MEM/WB write-back value.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] next_sel_addr,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      wb_sel,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wmask,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;

  logic            memop, aligned, done, start;
  logic [1:0]      size, off;
  logic [4:0]      cap_rd;
  logic            cap_reg_write, cap_uns;
  logic [1:0]      cap_size, cap_off, cap_wb_sel;
  logic [XLEN-1:0] cap_alu, cap_link, load_val, cmpl_data;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~ofs[0];
      2'b10:   is_aligned = (ofs == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] sz, input logic [XLEN-1:0] sd);
    case (sz)
      2'b00:   lane_data = {4{sd[7:0]}};
      2'b01:   lane_data = {2{sd[15:0]}};
      default: lane_data = sd;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << ofs;
      2'b01:   lane_mask = 4'b0011 << ofs;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Picks the addressed byte/halfword and sign- or zero-extends it.
  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] word,
                                                  input logic [1:0] ofs,
                                                  input logic [1:0] sz,
                                                  input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   load_align = uns ? {{(XLEN-8){1'b0}}, b}  : XLEN'(b);
      2'b01:   load_align = uns ? {{(XLEN-16){1'b0}}, h} : XLEN'(h);
      default: load_align = word;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                              input logic [XLEN-1:0] ld, input logic [XLEN-1:0] link);
    case (sel)
      2'b01:   wb_mux = ld;
      2'b10:   wb_mux = link;
      default: wb_mux = alu;
    endcase
  endfunction

  assign memop     = ex_valid & (mem_read | mem_write);
  assign size      = funct3[1:0];
  assign off       = alu_res[1:0];
  assign aligned   = is_aligned(size, off);
  assign start     = (state == IDLE) && memop && aligned;
  assign load_val  = load_align(dmem_rdata, cap_off, cap_size, cap_uns);
  assign cmpl_data = wb_mux(cap_wb_sel, cap_alu, load_val, cap_link);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (memop && aligned) state_nxt = REQ;
      REQ: begin
        if (dmem_gnt) begin
          if (dmem_we || dmem_rvalid) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_out = !rst && ((state == IDLE) ? (memop && aligned) : !done);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Captured request context: held until the access completes.
  always_ff @(posedge clk) begin
    if (start) begin
      cap_rd        <= rd;
      cap_reg_write <= reg_write;
      cap_uns       <= funct3[2];
      cap_size      <= size;
      cap_off       <= off;
      cap_wb_sel    <= wb_sel;
      cap_alu       <= alu_res;
      cap_link      <= next_sel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wmask   <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!memop) begin
            wb_valid     <= ex_valid;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
            wb_data      <= wb_mux(wb_sel, alu_res, alu_res, next_sel_addr);
          end else if (!aligned) begin
            wb_valid     <= 1'b1;
            wb_rd        <= rd;
            wb_reg_write <= 1'b0;
            wb_data      <= alu_res;
            misalign_err <= 1'b1;
          end else begin
            wb_valid     <= 1'b0;
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write;
            dmem_addr    <= {alu_res[XLEN-1:2], 2'b00};
            dmem_wdata   <= lane_data(size, store_data);
            dmem_wmask   <= mem_write ? lane_mask(size, off) : 4'b0000;
          end
        end
        REQ, RESP: begin
          if (done) begin
            wb_valid     <= 1'b1;
            wb_rd        <= cap_rd;
            wb_reg_write <= cap_reg_write & ~dmem_we;
            wb_data      <= cmpl_data;
            dmem_req     <= 1'b0;
          end else begin
            wb_valid <= 1'b0;
            if (state == REQ && dmem_gnt) dmem_req <= 1'b0;
          end
        end
        default: wb_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: write-back results are queued when an
// instruction is driven and compared when wb_valid appears.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_res, next_sel_addr, store_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_err;

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_res(alu_res),
    .next_sel_addr(next_sel_addr), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .wb_sel(wb_sel), .rd(rd), .reg_write(reg_write), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        dchk;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    funct3    = 3'b000;
  endtask

  task automatic push(input logic [4:0] r, input logic rw, input logic [31:0] d,
                      input logic dc, input logic m);
    exp_t e;
    e.rd = r; e.rw = rw; e.data = d; e.dchk = dc; e.mis = m;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
        chk("wb_misalign", 32'(misalign_err), 32'(mon_e.mis));
        if (mon_e.dchk) chk("wb_data", wb_data, mon_e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear_ex();
    alu_res = '0; next_sel_addr = '0; store_data = '0; rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    rst = 1'b0;

    // ALU op, one-cycle latency
    ex_valid = 1'b1; alu_res = 32'h1234; wb_sel = 2'b00; rd = 5'd5; reg_write = 1'b1;
    push(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0);
    #1 chk("alu_stall", 32'(stall_out), 32'd0);
    step();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    clear_ex();

    // LB signed at 0x103, gnt in cycle 2, rvalid in cycle 4
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b000; alu_res = 32'h103;
    wb_sel = 2'b01; rd = 5'd6; reg_write = 1'b1;
    push(5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
    #1 chk("lb_stall_c0", 32'(stall_out), 32'd1);
    step();
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", 32'(dmem_we), 32'd0);
    chk("lb_bubble", 32'(wb_valid), 32'd0);
    chk("lb_stall_c1", 32'(stall_out), 32'd1);
    step();
    dmem_gnt = 1'b1;
    #1 chk("lb_stall_c2", 32'(stall_out), 32'd1);
    step();
    dmem_gnt = 1'b0;
    chk("lb_req_drop", 32'(dmem_req), 32'd0);
    chk("lb_stall_c3", 32'(stall_out), 32'd1);
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1 chk("lb_stall_c4", 32'(stall_out), 32'd0);
    step();
    dmem_rvalid = 1'b0; clear_ex();

    // SH at 0x202 with grant delayed three cycles
    ex_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b001; alu_res = 32'h202;
    store_data = 32'hAAAA_BEEF; rd = 5'd7; reg_write = 1'b1;
    push(5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("sh_stall_c0", 32'(stall_out), 32'd1);
    step();
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_wmask", 32'(dmem_wmask), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_held", 32'(dmem_req), 32'd1);
      chk("sh_stall_wait", 32'(stall_out), 32'd1);
      step();
    end
    dmem_gnt = 1'b1;
    #1 chk("sh_stall_gnt", 32'(stall_out), 32'd0);
    chk("sh_req_gnt", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0; clear_ex();
    chk("sh_req_done", 32'(dmem_req), 32'd0);

    // LHU at 0x4 with gnt and rvalid together
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b101; alu_res = 32'h4;
    wb_sel = 2'b01; rd = 5'd8; reg_write = 1'b1;
    push(5'd8, 1'b1, 32'h0000_9ABC, 1'b1, 1'b0);
    step();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_9ABC;
    #1 chk("lhu_stall", 32'(stall_out), 32'd0);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; clear_ex();

    // Misaligned LW at 0x6
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_res = 32'h6;
    wb_sel = 2'b01; rd = 5'd9; reg_write = 1'b1;
    push(5'd9, 1'b0, 32'h0, 1'b0, 1'b1);
    #1 chk("mis_stall", 32'(stall_out), 32'd0);
    step();
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_err", 32'(misalign_err), 32'd1);
    clear_ex();
    step();
    chk("mis_err_pulse", 32'(misalign_err), 32'd0);

    // Reset during RESP, then a stray rvalid
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_res = 32'h10;
    wb_sel = 2'b01; rd = 5'd10; reg_write = 1'b1;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("rr_stall_resp", 32'(stall_out), 32'd1);
    rst = 1'b1;
    #1 chk("rr_stall_in_rst", 32'(stall_out), 32'd0);
    step();
    rst = 1'b0; clear_ex();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("rr_req", 32'(dmem_req), 32'd0);
    chk("rr_wmask", 32'(dmem_wmask), 32'd0);
    chk("rr_wb_valid", 32'(wb_valid), 32'd0);
    chk("rr_stall", 32'(stall_out), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    chk("rr_stray_wb", 32'(wb_valid), 32'd0);

    // ALU op after reset, then JAL link and wb_sel=11
    ex_valid = 1'b1; alu_res = 32'hCAFE; wb_sel = 2'b00; rd = 5'd3; reg_write = 1'b1;
    push(5'd3, 1'b1, 32'hCAFE, 1'b1, 1'b0);
    step();
    alu_res = 32'h999; next_sel_addr = 32'h2004; wb_sel = 2'b10; rd = 5'd1;
    push(5'd1, 1'b1, 32'h2004, 1'b1, 1'b0);
    step();
    alu_res = 32'h777; wb_sel = 2'b11; rd = 5'd2; reg_write = 1'b0;
    push(5'd2, 1'b0, 32'h777, 1'b1, 1'b0);
    step();
    clear_ex();
    step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
